// File: rtl/psimd_wb_if.sv
// Bundle/writeback bus between the PSIMD execution unit, the writeback
// stage and the vector register file. The master side produces result
// bundles and drives rf_ready and fflags_clr. The slave side is the
// writeback unit.
interface psimd_wb_if #(
    parameter int REG_WIDTH = 64,
    parameter int ADDR_W    = 5
);
    logic                 ex_valid;
    logic                 ex_ready;
    logic [1:0]           ex_kind;
    logic [ADDR_W-1:0]    ex_rd;
    logic [3:0]           ex_lane_en;
    logic [REG_WIDTH-1:0] ex_data;
    logic [REG_WIDTH-1:0] ex_datai_0;
    logic [REG_WIDTH-1:0] ex_datai_1;
    logic [3:0]           ex_invalid;
    logic [3:0]           ex_inexact;
    logic [3:0]           ex_overflow;
    logic [3:0]           ex_underflow;
    logic [3:0]           ex_div_by_zero;
    logic                 wb_we;
    logic [ADDR_W-1:0]    wb_addr;
    logic [REG_WIDTH-1:0] wb_data;
    logic                 rf_ready;
    logic [4:0]           fflags;
    logic                 fflags_clr;
    logic                 busy;

    modport master (
        output ex_valid, ex_kind, ex_rd, ex_lane_en, ex_data, ex_datai_0, ex_datai_1,
               ex_invalid, ex_inexact, ex_overflow, ex_underflow, ex_div_by_zero,
               rf_ready, fflags_clr,
        input  ex_ready, wb_we, wb_addr, wb_data, fflags, busy
    );

    modport slave (
        input  ex_valid, ex_kind, ex_rd, ex_lane_en, ex_data, ex_datai_0, ex_datai_1,
               ex_invalid, ex_inexact, ex_overflow, ex_underflow, ex_div_by_zero,
               rf_ready, fflags_clr,
        output ex_ready, wb_we, wb_addr, wb_data, fflags, busy
    );
endinterface

// File: rtl/psimd_writeback_unit.sv
// PSIMD writeback stage. Result bundles are buffered in a small FIFO and
// retired to the register file one 64-bit word per cycle: FP bundles
// write once, INT bundles write rd then rd+1, and flags-only bundles
// write nothing. Lane exceptions of a bundle are folded into the sticky
// fflags register at the moment that bundle leaves the FIFO.
module psimd_writeback_unit #(
    parameter int REG_WIDTH  = 64,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    psimd_wb_if.slave    bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] KIND_INT = 2'b01;

    // Flags are packed {invalid, div_by_zero, overflow, underflow, inexact},
    // four lanes each, so the fold below lines up directly with fflags.
    typedef struct packed {
        logic [1:0]           kind;
        logic [ADDR_W-1:0]    rd;
        logic [3:0]           laneEn;
        logic [REG_WIDTH-1:0] data;
        logic [REG_WIDTH-1:0] datai0;
        logic [REG_WIDTH-1:0] datai1;
        logic [19:0]          flags;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    entry_t               r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    state_t               r_state;
    logic                 r_wbWe;
    logic [ADDR_W-1:0]    r_wbAddr;
    logic [REG_WIDTH-1:0] r_wbData;
    logic [4:0]           r_fflags;

    entry_t               w_inEntry;
    entry_t               w_head0;
    entry_t               w_head1;
    logic                 w_head0Valid;
    logic                 w_head1Valid;
    logic [PTR_W-1:0]     w_rptrInc;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_commit;
    logic [4:0]           w_popFlags;

    // First word written for a bundle: the FP result or the low integer half.
    function automatic logic [REG_WIDTH-1:0] firstWord(input entry_t e);
        return (e.kind == KIND_INT) ? e.datai0 : e.data;
    endfunction

    assign w_inEntry.kind   = bus.ex_kind;
    assign w_inEntry.rd     = bus.ex_rd;
    assign w_inEntry.laneEn = bus.ex_lane_en;
    assign w_inEntry.data   = bus.ex_data;
    assign w_inEntry.datai0 = bus.ex_datai_0;
    assign w_inEntry.datai1 = bus.ex_datai_1;
    assign w_inEntry.flags  = {bus.ex_invalid, bus.ex_div_by_zero, bus.ex_overflow,
                               bus.ex_underflow, bus.ex_inexact};

    assign w_full    = (r_count == CNT_FULL);
    assign w_push    = bus.ex_valid && !w_full;
    assign w_commit  = r_wbWe && bus.rf_ready;
    assign w_rptrInc = r_rptr + 1'b1;

    // Head views: when the FIFO runs dry the incoming bundle is presented
    // in the same cycle, so a bundle accepted into an empty FIFO reaches
    // the write port one cycle later and back-to-back FP writes never stall.
    assign w_head0Valid = (r_count != CNT_ZERO) || w_push;
    assign w_head0      = (r_count != CNT_ZERO) ? r_mem[r_rptr] : w_inEntry;
    assign w_head1Valid = (r_count > CNT_ONE) || ((r_count == CNT_ONE) && w_push);
    assign w_head1      = (r_count > CNT_ONE) ? r_mem[w_rptrInc] : w_inEntry;

    assign w_popFlags = {|(w_head0.flags[19:16] & w_head0.laneEn),
                         |(w_head0.flags[15:12] & w_head0.laneEn),
                         |(w_head0.flags[11:8]  & w_head0.laneEn),
                         |(w_head0.flags[7:4]   & w_head0.laneEn),
                         |(w_head0.flags[3:0]   & w_head0.laneEn)};

    // Decide whether the head bundle leaves the FIFO this cycle.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:    w_pop = w_head0Valid && w_head0.kind[1];
            WR_LO:   w_pop = w_commit && (w_head0.kind != KIND_INT);
            WR_HI:   w_pop = w_commit;
            default: w_pop = 1'b0;
        endcase
    end

    // Bundle storage; contents need no reset because occupancy guards them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_inEntry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= w_rptrInc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Writer FSM driving the registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wbWe   <= 1'b0;
            r_wbAddr <= '0;
            r_wbData <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_head0Valid && !w_head0.kind[1]) begin
                        r_wbWe   <= 1'b1;
                        r_wbAddr <= w_head0.rd;
                        r_wbData <= firstWord(w_head0);
                        r_state  <= WR_LO;
                    end
                end
                WR_LO, WR_HI: begin
                    if (w_commit) begin
                        if ((r_state == WR_LO) && (w_head0.kind == KIND_INT)) begin
                            r_wbAddr <= w_head0.rd + 1'b1;
                            r_wbData <= w_head0.datai1;
                            r_state  <= WR_HI;
                        end else if (w_head1Valid && !w_head1.kind[1]) begin
                            r_wbAddr <= w_head1.rd;
                            r_wbData <= firstWord(w_head1);
                            r_state  <= WR_LO;
                        end else begin
                            r_wbWe  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_wbWe  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky exception flags; bits of a popping bundle survive a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fflags <= '0;
        end else if (w_pop) begin
            r_fflags <= (bus.fflags_clr ? 5'b0 : r_fflags) | w_popFlags;
        end else if (bus.fflags_clr) begin
            r_fflags <= '0;
        end
    end

    assign bus.ex_ready = !w_full;
    assign bus.wb_we    = r_wbWe;
    assign bus.wb_addr  = r_wbAddr;
    assign bus.wb_data  = r_wbData;
    assign bus.fflags   = r_fflags;
    assign bus.busy     = (r_count != CNT_ZERO) || r_wbWe;

endmodule

// File: tb/tb_psimd_writeback_unit.sv
// Directed self-checking bench for psimd_writeback_unit. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_psimd_writeback_unit;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    psimd_wb_if #(.REG_WIDTH(64), .ADDR_W(5)) bus ();

    psimd_writeback_unit #(.REG_WIDTH(64), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearInputs();
        bus.ex_valid       = 1'b0;
        bus.ex_kind        = 2'b00;
        bus.ex_rd          = 5'd0;
        bus.ex_lane_en     = 4'b0000;
        bus.ex_data        = 64'd0;
        bus.ex_datai_0     = 64'd0;
        bus.ex_datai_1     = 64'd0;
        bus.ex_invalid     = 4'b0;
        bus.ex_inexact     = 4'b0;
        bus.ex_overflow    = 4'b0;
        bus.ex_underflow   = 4'b0;
        bus.ex_div_by_zero = 4'b0;
        bus.rf_ready       = 1'b1;
        bus.fflags_clr     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] kind, input logic [4:0] rd,
                                 input logic [3:0] en, input logic [63:0] data,
                                 input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [3:0] inv, input logic [3:0] of,
                                 input logic [3:0] nx);
        bus.ex_valid       = 1'b1;
        bus.ex_kind        = kind;
        bus.ex_rd          = rd;
        bus.ex_lane_en     = en;
        bus.ex_data        = data;
        bus.ex_datai_0     = d0;
        bus.ex_datai_1     = d1;
        bus.ex_invalid     = inv;
        bus.ex_overflow    = of;
        bus.ex_inexact     = nx;
        bus.ex_underflow   = 4'b0;
        bus.ex_div_by_zero = 4'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, FP/INT writes, backpressure, flags and reset abort.
    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk);

        checkOutput("rst_we",    64'(bus.wb_we),    64'd0);
        checkOutput("rst_addr",  64'(bus.wb_addr),  64'd0);
        checkOutput("rst_data",  bus.wb_data,       64'd0);
        checkOutput("rst_flags", 64'(bus.fflags),   64'd0);
        checkOutput("rst_ready", 64'(bus.ex_ready), 64'd1);
        checkOutput("rst_busy",  64'(bus.busy),     64'd0);
        rst_n = 1'b1;
        tick();

        // FP single write, visible the cycle after acceptance, for one cycle.
        applyStimulus(2'b00, 5'd3, 4'b1111, 64'h3C00_3C00_3C00_3C00, 64'd0, 64'd0, 4'b0, 4'b0, 4'b0);
        tick();
        bus.ex_valid = 1'b0;
        checkOutput("fp_we",   64'(bus.wb_we),   64'd1);
        checkOutput("fp_addr", 64'(bus.wb_addr), 64'd3);
        checkOutput("fp_data", bus.wb_data,      64'h3C00_3C00_3C00_3C00);
        tick();
        checkOutput("fp_we_off", 64'(bus.wb_we),  64'd0);
        checkOutput("fp_busy",   64'(bus.busy),   64'd0);
        checkOutput("fp_flags",  64'(bus.fflags), 64'd0);

        // Two FP bundles back to back at full throughput.
        applyStimulus(2'b00, 5'd10, 4'b1111, 64'hAAAA_0000_AAAA_0000, 64'd0, 64'd0, 4'b0, 4'b0, 4'b0);
        tick();
        checkOutput("b2b_addr0", 64'(bus.wb_addr), 64'd10);
        applyStimulus(2'b00, 5'd11, 4'b1111, 64'hBBBB_0000_BBBB_0000, 64'd0, 64'd0, 4'b0, 4'b0, 4'b0);
        tick();
        bus.ex_valid = 1'b0;
        checkOutput("b2b_we1",   64'(bus.wb_we),   64'd1);
        checkOutput("b2b_addr1", 64'(bus.wb_addr), 64'd11);
        checkOutput("b2b_data1", bus.wb_data,      64'hBBBB_0000_BBBB_0000);
        tick();
        checkOutput("b2b_we_off", 64'(bus.wb_we), 64'd0);

        // INT pair with rd+1 wrapping from 31 to 0.
        applyStimulus(2'b01, 5'd31, 4'b1111, 64'd0, 64'h1111_1111_1111_1111,
                      64'h2222_2222_2222_2222, 4'b0, 4'b0, 4'b0);
        tick();
        bus.ex_valid = 1'b0;
        checkOutput("int_lo_we",   64'(bus.wb_we),   64'd1);
        checkOutput("int_lo_addr", 64'(bus.wb_addr), 64'd31);
        checkOutput("int_lo_data", bus.wb_data,      64'h1111_1111_1111_1111);
        tick();
        checkOutput("int_hi_we",   64'(bus.wb_we),   64'd1);
        checkOutput("int_hi_addr", 64'(bus.wb_addr), 64'd0);
        checkOutput("int_hi_data", bus.wb_data,      64'h2222_2222_2222_2222);
        tick();
        checkOutput("int_we_off", 64'(bus.wb_we), 64'd0);

        // Backpressure: fill the FIFO while the register file stalls.
        bus.rf_ready = 1'b0;
        applyStimulus(2'b00, 5'd5, 4'b1111, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 64'd0, 4'b0, 4'b0, 4'b0);
        tick();
        applyStimulus(2'b00, 5'd6, 4'b1111, 64'hBBBB_BBBB_BBBB_BBBB, 64'd0, 64'd0, 4'b0, 4'b0, 4'b0);
        tick();
        bus.ex_valid = 1'b0;
        checkOutput("bp_ready", 64'(bus.ex_ready), 64'd0);
        checkOutput("bp_we",    64'(bus.wb_we),    64'd1);
        tick();
        checkOutput("bp_hold_addr", 64'(bus.wb_addr), 64'd5);
        checkOutput("bp_hold_data", bus.wb_data,      64'hAAAA_AAAA_AAAA_AAAA);
        checkOutput("bp_busy",      64'(bus.busy),    64'd1);
        bus.rf_ready = 1'b1;
        tick();
        checkOutput("bp_second_addr", 64'(bus.wb_addr),  64'd6);
        checkOutput("bp_second_data", bus.wb_data,       64'hBBBB_BBBB_BBBB_BBBB);
        checkOutput("bp_ready_back",  64'(bus.ex_ready), 64'd1);
        tick();
        checkOutput("bp_we_off", 64'(bus.wb_we), 64'd0);

        // Lane masking of exception bits on flags-only bundles.
        applyStimulus(2'b10, 5'd0, 4'b0111, 64'd0, 64'd0, 64'd0, 4'b0, 4'b1000, 4'b0);
        tick();
        bus.ex_valid = 1'b0;
        checkOutput("mask_off_flags", 64'(bus.fflags), 64'd0);
        checkOutput("mask_no_write",  64'(bus.wb_we),  64'd0);
        applyStimulus(2'b11, 5'd0, 4'b1000, 64'd0, 64'd0, 64'd0, 4'b0, 4'b1000, 4'b0);
        tick();
        bus.ex_valid = 1'b0;
        checkOutput("mask_on_flags", 64'(bus.fflags), 64'h04);
        tick();
        checkOutput("flags_sticky", 64'(bus.fflags), 64'h04);

        // Clear alone, then clear colliding with a pop.
        bus.fflags_clr = 1'b1;
        tick();
        bus.fflags_clr = 1'b0;
        checkOutput("clr_only", 64'(bus.fflags), 64'd0);
        applyStimulus(2'b10, 5'd0, 4'b1111, 64'd0, 64'd0, 64'd0, 4'b0001, 4'b0, 4'b0);
        tick();
        checkOutput("set_nv", 64'(bus.fflags), 64'h10);
        applyStimulus(2'b10, 5'd0, 4'b1111, 64'd0, 64'd0, 64'd0, 4'b0, 4'b0, 4'b0001);
        bus.fflags_clr = 1'b1;
        tick();
        bus.ex_valid   = 1'b0;
        bus.fflags_clr = 1'b0;
        checkOutput("clr_set_collide", 64'(bus.fflags), 64'h01);

        // Reset while the high half of an INT write is pending.
        applyStimulus(2'b01, 5'd7, 4'b1111, 64'd0, 64'h7777_7777_7777_7777,
                      64'h8888_8888_8888_8888, 4'b0, 4'b0, 4'b0);
        tick();
        bus.ex_valid = 1'b0;
        tick();
        checkOutput("rhi_addr", 64'(bus.wb_addr), 64'd8);
        rst_n = 1'b0;
        #1;
        checkOutput("rhi_we_async", 64'(bus.wb_we), 64'd0);
        checkOutput("rhi_busy",     64'(bus.busy),  64'd0);
        checkOutput("rhi_flags",    64'(bus.fflags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("rhi_post_we1", 64'(bus.wb_we), 64'd0);
        tick();
        checkOutput("rhi_post_we2",   64'(bus.wb_we),    64'd0);
        checkOutput("rhi_post_busy",  64'(bus.busy),     64'd0);
        checkOutput("rhi_post_ready", 64'(bus.ex_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
